stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter N_OUT, default 4, number of output channels, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(N_OUT), selector width; derived, not overridden.
REQ-004 The block SHALL have one clock and one reset, with the reset synchronous and active-low; the ports are named as follows.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  input word present.
REQ-008 in_ready  output  1  block accepts the input word this cycle.
REQ-009 in_data  input  DATA_W  input word.
REQ-010 in_sel  input  SEL_W  destination channel index.
REQ-011 in_bcast  input  1  1 = deliver the word to every channel; in_sel is then ignored.
REQ-012 out_valid  output  N_OUT  per-channel word present.
REQ-013 out_ready  input  N_OUT  per-channel consumer accepts.
REQ-014 out_data  output  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-015 drop_pulse  output  1  one-cycle pulse when a word is discarded.
REQ-016 drop_cnt  output  16  saturating count of discarded words.

Function
REQ-017 Each channel SHALL hold a one-entry register slot (EMPTY/FULL) that drives out_valid[k] = FULL and out_data[k] = the stored word.
REQ-018 out_data for an EMPTY channel SHALL be all zeros.
REQ-019 Input transfer occurs when in_valid && in_ready; output transfer on channel k occurs when out_valid[k] && out_ready[k].
REQ-020 A slot can accept when it is EMPTY or is being drained in the same cycle.
REQ-021 Unicast (in_bcast=0, in_sel<N_OUT): in_ready SHALL equal "slot in_sel can accept".
REQ-022 Broadcast (in_bcast=1): in_ready SHALL be 1 only when all N_OUT slots can accept; on transfer, every slot loads in_data.
REQ-023 Invalid selector (in_bcast=0, in_sel>=N_OUT): in_ready SHALL be 1, the word is discarded, drop_pulse=1 next cycle, and drop_cnt increments.
REQ-024 drop_cnt SHALL saturate at 16'hFFFF.
REQ-025 Latency SHALL be exactly 1 cycle: a word accepted at edge t is visible on out_valid/out_data after edge t.
REQ-026 Simultaneous drain and load of the same slot SHALL leave it FULL with the new word, with no bubble.
REQ-027 A FULL slot SHALL hold its word stable until drained, regardless of the input.
REQ-028 in_ready is combinational from in_sel, in_bcast and out_ready; it SHALL NOT depend on in_valid.
REQ-029 Channel order SHALL NOT be reordered: words to one channel exit in acceptance order.
REQ-030 With N_OUT=2, channel 0 is the ALU path and channel 1 the Buffer2 path, selected as the former op bit.

Reset
REQ-031 When rst_n=0 at a rising edge: all slots become EMPTY, out_valid=0, out_data=0, drop_pulse=0, drop_cnt=0.
REQ-032 Reset mid-transfer SHALL discard stored words without emitting them; in_ready is forced to 0 while rst_n=0.

Structure
REQ-033 The shared package SHALL hold the slot-state enum (EMPTY, FULL) and the default DATA_W/N_OUT constants.
REQ-034 A sub-module demux_slot (one-entry register with load/drain/valid) SHALL be instantiated N_OUT times via generate.

Verification
REQ-035 Unicast: sel=2, data=32'hA5A5_0001, out_ready=4'b1111 -> out_valid=4'b0100 one cycle later, out_data[2]=32'hA5A5_0001, all other channels 0.
REQ-036 Backpressure: out_ready[1]=0 with two words sent to sel=1 -> first held stable, in_ready=0 for the second; the second is accepted on the cycle out_ready[1] rises, with no bubble.
REQ-037 Broadcast: bcast=1, data=32'h1234_5678, out_ready[3]=0 while slot 3 is FULL -> in_ready=0; after slot 3 drains, all four slots load 32'h1234_5678.
REQ-038 Invalid select with N_OUT=3: sel=3 -> in_ready=1, no out_valid, drop_pulse for one cycle, drop_cnt=1; force drop_cnt=16'hFFFF, then drop again -> stays 16'hFFFF.
REQ-039 Reset mid-operation: slots 0 and 2 FULL, rst_n=0 for one edge -> out_valid=0, out_data=0, drop_cnt=0 on the next cycle.
REQ-040 Random traffic with random out_ready, 10k words -> a scoreboard shows per-channel order and data preserved, with zero loss for valid selectors.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
package stream_demux_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_N_OUT  = 4;
  localparam int DROP_CNT_W     = 16;

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

  // Occupancy of a one-entry channel slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Increment that sticks at the maximum value instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    logic [DROP_CNT_W-1:0] r;
    if (v == DROP_CNT_MAX) begin
      r = v;
    end else begin
      r = v + DROP_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle between a single producer and the N_OUT channel consumers.
// Channel k of out_data occupies bits [k*DATA_W +: DATA_W].
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N_OUT  = DEFAULT_N_OUT
);
  localparam int SEL_W = $clog2(N_OUT);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;

  // Producer / consumer side (the environment around the demux).
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single channel. Loads and drains may
// coincide, in which case the new word replaces the old one with no bubble.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              can_accept_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              drain_s;

  // Next-state logic: the stored word is cleared when the slot empties so
  // an idle channel always presents zeros.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    drain_s      = (state_q == SLOT_FULL) && ready_i;
    can_accept_o = (state_q == SLOT_EMPTY) || ready_i;
    case (state_q)
      SLOT_EMPTY: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (load_i) begin
          data_d = data_i;
        end else if (drain_s) begin
          state_d = SLOT_EMPTY;
          data_d  = '0;
        end else begin
          state_d = SLOT_FULL;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
        data_d  = '0;
      end
    endcase
  end

  // Slot state and word register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Stream demultiplexer: routes each input word to one channel (or to all of
// them when broadcasting) through a one-entry slot per channel. Words with an
// out-of-range selector are accepted and discarded, and counted.
// With N_OUT=2, channel 0 is the ALU path and channel 1 the Buffer2 path.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N_OUT  = DEFAULT_N_OUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_demux_if.slave         bus,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int SEL_W = $clog2(N_OUT);

  logic [N_OUT-1:0]        sel_hit_s;
  logic [N_OUT-1:0]        can_accept_s;
  logic [N_OUT-1:0]        load_s;
  logic [N_OUT-1:0]        out_valid_s;
  logic [N_OUT*DATA_W-1:0] out_data_s;
  logic                    sel_ok_s;
  logic                    in_ready_s;
  logic                    xfer_s;
  logic                    drop_d, drop_pulse_q;
  logic [DROP_CNT_W-1:0]   drop_cnt_d, drop_cnt_q;

  // Selector decode, acceptance decision and per-slot load enables. in_ready
  // never looks at in_valid so a producer may wait on it before asserting.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      sel_hit_s[k] = (bus.in_sel == SEL_W'(k));
    end
    sel_ok_s = |sel_hit_s;

    if (!rst_n) begin
      in_ready_s = 1'b0;
    end else if (bus.in_bcast) begin
      in_ready_s = &can_accept_s;
    end else if (!sel_ok_s) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = |(sel_hit_s & can_accept_s);
    end

    xfer_s = bus.in_valid && in_ready_s;

    if (!xfer_s) begin
      load_s = '0;
    end else if (bus.in_bcast) begin
      load_s = '1;
    end else begin
      load_s = sel_hit_s;
    end

    drop_d     = xfer_s && !bus.in_bcast && !sel_ok_s;
    drop_cnt_d = drop_d ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  // Discard indication and saturating discard counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load_s[k]),
      .ready_i      (bus.out_ready[k]),
      .data_i       (bus.in_data),
      .can_accept_o (can_accept_s[k]),
      .valid_o      (out_valid_s[k]),
      .data_o       (out_data_s[k*DATA_W +: DATA_W])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign drop_pulse    = drop_pulse_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: a 4-channel instance carries directed and
// random traffic, a 3-channel instance exercises the discard path.
module tb_stream_demux;

  localparam int DW = 32;

  typedef logic [DW-1:0] word_q_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(DW), .N_OUT(4)) bus4 ();
  stream_demux_if #(.DATA_W(DW), .N_OUT(3)) bus3 ();

  logic        dp4, dp3;
  logic [15:0] dc4, dc3;

  stream_demux #(.DATA_W(DW), .N_OUT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .drop_pulse(dp4), .drop_cnt(dc4)
  );
  stream_demux #(.DATA_W(DW), .N_OUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .drop_pulse(dp3), .drop_cnt(dc3)
  );

  int      n_checks = 0;
  int      n_fail   = 0;
  bit      mon_en   = 1'b0;
  word_q_t sb[4];   // words accepted per channel, not yet drained

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every channel must show exactly what the scoreboard holds.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      for (int k = 0; k < 4; k++) begin
        logic [DW-1:0] dat;
        dat = bus4.out_data[k*DW +: DW];
        check($sformatf("out_valid[%0d]", k), 128'(bus4.out_valid[k]), 128'(sb[k].size() != 0));
        if (sb[k].size() != 0) begin
          check($sformatf("out_data[%0d]", k), 128'(dat), 128'(sb[k][0]));
          if (bus4.out_ready[k]) void'(sb[k].pop_front());
        end else begin
          check($sformatf("idle_data[%0d]", k), 128'(dat), 128'(0));
        end
      end
    end
  end

  // One clock of stimulus on the 4-channel instance; in_ready is predicted
  // from the scoreboard occupancy and accepted words are queued.
  task automatic cycle(input bit v, input bit b, input logic [1:0] s,
                       input logic [DW-1:0] d, input logic [3:0] ordy, output bit acc);
    bit exp_rdy;
    bus4.in_valid  = v;
    bus4.in_bcast  = b;
    bus4.in_sel    = s;
    bus4.in_data   = d;
    bus4.out_ready = ordy;
    @(negedge clk);
    if (b) begin
      exp_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (!(sb[k].size() == 0 || ordy[k])) exp_rdy = 1'b0;
      end
    end else begin
      exp_rdy = (sb[s].size() == 0) || ordy[s];
    end
    check("in_ready", 128'(bus4.in_ready), 128'(exp_rdy));
    acc = v && bus4.in_ready;
    @(posedge clk);
    if (acc) begin
      if (b) begin
        for (int k = 0; k < 4; k++) sb[k].push_back(d);
      end else begin
        sb[s].push_back(d);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111, a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int accepted;
    int iters;

    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_bcast  = 1'b0;
    bus4.in_sel    = 2'd0;
    bus4.in_data   = 32'h0;
    bus4.out_ready = 4'b1111;
    bus3.in_valid  = 1'b0;
    bus3.in_bcast  = 1'b0;
    bus3.in_sel    = 2'd0;
    bus3.in_data   = 32'h0;
    bus3.out_ready = 3'b111;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(bus4.in_ready), 128'(0));
    check("rst_out_valid", 128'(bus4.out_valid), 128'(0));
    check("rst_out_data", bus4.out_data, 128'(0));
    check("rst_drop_pulse", 128'(dp4), 128'(0));
    check("rst_drop_cnt", 128'(dc4), 128'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Unicast to channel 2
    cycle(1'b1, 1'b0, 2'd2, 32'hA5A5_0001, 4'b1111, acc);
    check("uni_acc", 128'(acc), 128'(1));
    check("uni_valid", 128'(bus4.out_valid), 128'(4'b0100));
    check("uni_data", bus4.out_data, {32'h0, 32'hA5A5_0001, 32'h0, 32'h0});
    idle(2);

    // Backpressure on channel 1
    cycle(1'b1, 1'b0, 2'd1, 32'h1111_0001, 4'b1101, acc);
    check("bp_first_acc", 128'(acc), 128'(1));
    cycle(1'b1, 1'b0, 2'd1, 32'h1111_0002, 4'b1101, acc);
    check("bp_second_refused", 128'(acc), 128'(0));
    cycle(1'b1, 1'b0, 2'd1, 32'h1111_0002, 4'b1101, acc);
    check("bp_hold_data", 128'(bus4.out_data[1*DW +: DW]), 128'(32'h1111_0001));
    cycle(1'b1, 1'b0, 2'd1, 32'h1111_0002, 4'b1111, acc);
    check("bp_no_bubble", 128'(acc), 128'(1));
    check("bp_second_data", 128'(bus4.out_data[1*DW +: DW]), 128'(32'h1111_0002));
    idle(2);

    // Broadcast blocked by full channel 3, then released as it drains
    cycle(1'b1, 1'b0, 2'd3, 32'h3333_0003, 4'b0111, acc);
    cycle(1'b1, 1'b1, 2'd0, 32'h1234_5678, 4'b0111, acc);
    check("bc_blocked", 128'(acc), 128'(0));
    cycle(1'b1, 1'b1, 2'd0, 32'h1234_5678, 4'b1111, acc);
    check("bc_acc", 128'(acc), 128'(1));
    check("bc_valid", 128'(bus4.out_valid), 128'(4'b1111));
    check("bc_data", bus4.out_data, {4{32'h1234_5678}});
    idle(2);

    // Invalid selector on the 3-channel instance
    bus3.in_valid = 1'b1;
    bus3.in_sel   = 2'd3;
    bus3.in_data  = 32'hDEAD_BEEF;
    #1;
    check("inv_in_ready", 128'(bus3.in_ready), 128'(1));
    @(posedge clk);
    #1;
    bus3.in_valid = 1'b0;
    check("inv_no_valid", 128'(bus3.out_valid), 128'(0));
    check("inv_pulse", 128'(dp3), 128'(1));
    check("inv_cnt", 128'(dc3), 128'(1));
    @(posedge clk);
    #1;
    check("inv_pulse_end", 128'(dp3), 128'(0));
    force dut3.drop_cnt_q = 16'hFFFF;
    #1;
    release dut3.drop_cnt_q;
    bus3.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus3.in_valid = 1'b0;
    check("sat_pulse", 128'(dp3), 128'(1));
    check("sat_cnt", 128'(dc3), 128'(16'hFFFF));

    // Reset with channels 0 and 2 holding words
    cycle(1'b1, 1'b0, 2'd0, 32'h0000_AAAA, 4'b0000, acc);
    cycle(1'b1, 1'b0, 2'd2, 32'h0000_CCCC, 4'b0000, acc);
    bus4.in_valid = 1'b1;
    bus4.in_sel   = 2'd1;
    rst_n         = 1'b0;
    #1;
    check("rst_forces_ready_low", 128'(bus4.in_ready), 128'(0));
    @(posedge clk);
    for (int k = 0; k < 4; k++) sb[k].delete();
    #1;
    rst_n         = 1'b1;
    bus4.in_valid = 1'b0;
    check("mid_rst_valid", 128'(bus4.out_valid), 128'(0));
    check("mid_rst_data", bus4.out_data, 128'(0));
    check("mid_rst_drop_cnt", 128'(dc3), 128'(0));
    check("mid_rst_drop_pulse", 128'(dp3), 128'(0));

    // Random traffic with random per-channel backpressure
    accepted = 0;
    iters    = 0;
    while (accepted < 10000 && iters < 40000) begin
      logic [3:0] ordy;
      for (int k = 0; k < 4; k++) ordy[k] = ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            2'($urandom_range(0, 3)), $urandom, ordy, acc);
      if (acc) accepted++;
      iters++;
    end
    check("random_word_count", 128'(accepted), 128'(10000));
    idle(3);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sb_empty[%0d]", k), 128'(sb[k].size()), 128'(0));
    end
    check("no_drops_4ch", 128'(dc4), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
